// File: rtl/cam_conv_arbiter.sv
// Round-robin arbiter that shares one YUV422->RGB565 converter between
// several camera FIFOs, one fixed-length, pair-aligned burst at a time.
module cam_conv_arbiter #(
    parameter int N_CAM = 4,
    parameter int BURST = 64,
    parameter int CNT_W = 11,
    parameter int ID_W  = 2
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [N_CAM*CNT_W-1:0] fifo_cnt_i,
    input  logic [N_CAM*16-1:0]    fifo_data_i,
    output logic [N_CAM-1:0]       fifo_rd_o,
    output logic                   conv_de_o,
    output logic [15:0]            conv_data_o,
    output logic [ID_W-1:0]        sel_id_o,
    output logic                   busy_o,
    output logic                   burst_done_o
);

    localparam int WC_W = (BURST > 4) ? $clog2(BURST) : 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state_q;
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  sel_q;
    logic [WC_W-1:0]  wcnt_q;
    logic [N_CAM-1:0] rd_q;
    logic             de_q;
    logic [15:0]      data_q;
    logic             busy_q;
    logic             done_q;

    logic [ID_W-1:0]  pick;
    logic             found;
    int               scan_idx;
    logic [15:0]      rd_word;
    logic [ID_W-1:0]  rr_d;

    // First camera at or after rr_q (wrapping) holding a full burst
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = 0; i < N_CAM; i++) begin
            scan_idx = (int'(rr_q) + i) % N_CAM;
            if (!found &&
                fifo_cnt_i[scan_idx*CNT_W +: CNT_W] >= CNT_W'(BURST)) begin
                found = 1'b1;
                pick  = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_CAM; k++) begin
            if (sel_q == ID_W'(k)) begin
                rd_word = fifo_data_i[k*16 +: 16];
            end
        end
    end

    assign rr_d = (sel_q == ID_W'(N_CAM-1)) ? '0 : sel_q + ID_W'(1);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            wcnt_q  <= '0;
            rd_q    <= '0;
            de_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            de_q   <= |rd_q;
            done_q <= 1'b0;
            if (|rd_q) begin
                data_q <= rd_word;
            end
            unique case (state_q)
                IDLE: begin
                    if (enable_i && found) begin
                        sel_q   <= pick;
                        rd_q    <= N_CAM'(1) << pick;
                        busy_q  <= 1'b1;
                        wcnt_q  <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (wcnt_q == WC_W'(BURST-1)) begin
                        rd_q    <= '0;
                        wcnt_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        wcnt_q <= wcnt_q + WC_W'(1);
                    end
                end
                DRAIN: begin
                    // One FIFO-latency cycle, then two for the second pixel
                    if (wcnt_q == WC_W'(2)) begin
                        busy_q  <= 1'b0;
                        rr_q    <= rr_d;
                        wcnt_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + WC_W'(1);
                        if (wcnt_q == WC_W'(1)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_rd_o    = rd_q;
    assign conv_de_o    = de_q;
    assign conv_data_o  = data_q;
    assign sel_id_o     = sel_q;
    assign busy_o       = busy_q;
    assign burst_done_o = done_q;

endmodule

// File: tb/tb_cam_conv_arbiter.sv
// Bench for cam_conv_arbiter: FIFO models, word scoreboard, burst monitor
// and a small reference YUV->RGB565 converter on the output stream.
module tb_cam_conv_arbiter;

    localparam int N  = 4;
    localparam int B  = 64;
    localparam int CW = 11;
    localparam int IW = 2;

    logic            pclk = 1'b0;
    logic            rst = 1'b1;
    logic            enable_i = 1'b0;
    logic [N*CW-1:0] fifo_cnt_i;
    logic [N*16-1:0] fifo_data_i;
    logic [N-1:0]    fifo_rd_o;
    logic            conv_de_o;
    logic [15:0]     conv_data_o;
    logic [IW-1:0]   sel_id_o;
    logic            busy_o;
    logic            burst_done_o;

    cam_conv_arbiter #(.N_CAM(N), .BURST(B), .CNT_W(CW), .ID_W(IW)) dut (
        .pclk(pclk), .rst(rst), .enable_i(enable_i),
        .fifo_cnt_i(fifo_cnt_i), .fifo_data_i(fifo_data_i),
        .fifo_rd_o(fifo_rd_o), .conv_de_o(conv_de_o),
        .conv_data_o(conv_data_o), .sel_id_o(sel_id_o),
        .busy_o(busy_o), .burst_done_o(burst_done_o)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // FIFO models: count = written - read, read data shown for current pointer
    int fill[N];
    int rdptr[N];
    bit pat3 = 1'b0;

    function automatic logic [15:0] word_of(input int k, input int p);
        if (pat3 && k == 3) return p[0] ? 16'h8010 : 16'h80EB;
        return {4'(k), 12'(p)};
    endfunction

    always_comb begin
        fifo_cnt_i  = '0;
        fifo_data_i = '0;
        for (int k = 0; k < N; k++) begin
            fifo_cnt_i[k*CW +: CW]  = CW'(fill[k] - rdptr[k]);
            fifo_data_i[k*16 +: 16] = word_of(k, rdptr[k]);
        end
    end

    always @(posedge pclk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) rdptr[k] <= 0;
            else if (fifo_rd_o[k]) rdptr[k] <= rdptr[k] + 1;
        end
    end

    function automatic logic [15:0] rgb565(input int y, input int u, input int v);
        int c, d, e, r, g, b;
        logic [7:0] r8, g8, b8;
        c = y - 16; d = u - 128; e = v - 128;
        r = (298*c + 409*e + 128) >>> 8;
        g = (298*c - 100*d - 208*e + 128) >>> 8;
        b = (298*c + 516*d + 128) >>> 8;
        r = (r < 0) ? 0 : (r > 255) ? 255 : r;
        g = (g < 0) ? 0 : (g > 255) ? 255 : g;
        b = (b < 0) ? 0 : (b > 255) ? 255 : b;
        r8 = 8'(r); g8 = 8'(g); b8 = 8'(b);
        return {r8[7:3], g8[7:2], b8[7:3]};
    endfunction

    typedef struct {
        logic [15:0] d;
        int          s;
    } exp_t;

    exp_t exp_q[$];
    int   exp_ptr[N];

    // Monitor records
    int g_sel[$], g_len[$], g_rise[$], g_last[$], d_cyc[$];
    int cur_len, last_rd, rd_cycles, de_cycles, de_first, de_last;
    bit prev_rd, half, pix_seen;
    logic [15:0] w0, pix0, pix1;
    int pix_sel, pix_cyc;

    task automatic clear_mon();
        g_sel.delete(); g_len.delete(); g_rise.delete();
        g_last.delete(); d_cyc.delete(); exp_q.delete();
        cur_len = 0; rd_cycles = 0; de_cycles = 0;
        de_first = -1; de_last = -1; prev_rd = 0; half = 0;
        pix_seen = 0;
        for (int k = 0; k < N; k++) exp_ptr[k] = 0;
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (fifo_rd_o != '0) begin
            if (!prev_rd) begin
                g_rise.push_back(cyc);
                g_sel.push_back(int'(sel_id_o));
                cur_len = 0;
            end
            cur_len++;
            rd_cycles++;
            last_rd = cyc;
            prev_rd = 1;
            chk("rd_onehot", fifo_rd_o, 1 << sel_id_o);
            chk("busy_in_read", busy_o, 1);
        end else if (prev_rd) begin
            g_len.push_back(cur_len);
            g_last.push_back(last_rd);
            prev_rd = 0;
        end
        if (conv_de_o) begin
            de_cycles++;
            if (de_first < 0) de_first = cyc;
            de_last = cyc;
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL de_unexpected: word 0x%0h with no expected entry at cycle %0d",
                         conv_data_o, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("conv_data", conv_data_o, e.d);
                chk("sel_tag", sel_id_o, e.s);
            end
            if (!half) begin
                w0 = conv_data_o;
            end else if (!pix_seen) begin
                pix0 = rgb565(int'(w0[7:0]), int'(w0[15:8]), int'(conv_data_o[15:8]));
                pix1 = rgb565(int'(conv_data_o[7:0]), int'(w0[15:8]), int'(conv_data_o[15:8]));
                pix_sel = int'(sel_id_o);
                pix_cyc = cyc;
                pix_seen = 1;
            end
            half = ~half;
        end
        if (burst_done_o) d_cyc.push_back(cyc);
    end

    task automatic push_burst(input int k);
        for (int i = 0; i < B; i++) begin
            exp_q.push_back('{word_of(k, exp_ptr[k]), k});
            exp_ptr[k]++;
        end
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < N; k++) fill[k] = rdptr[k] + v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pat3 = 1'b0;
        for (int k = 0; k < N; k++) fill[k] = 0;
        @(posedge pclk); #1;
        chk("rst_rd", fifo_rd_o, 0);
        chk("rst_de", conv_de_o, 0);
        chk("rst_data", conv_data_o, 0);
        chk("rst_sel", sel_id_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", burst_done_o, 0);
        @(posedge pclk); #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int t = 0; t < budget && d_cyc.size() < n; t++) @(posedge pclk);
        #1;
        chk("done_count", d_cyc.size(), n);
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int t = 0; t < budget && g_rise.size() < n; t++) @(posedge pclk);
        #1;
        chk("grant_seen", g_rise.size(), n);
    endtask

    task automatic wait_len(input int n, input int budget);
        for (int t = 0; t < budget && cur_len < n; t++) @(posedge pclk);
        #1;
        chk("reads_reached", (cur_len >= n), 1);
    endtask

    int c0;

    initial begin
        clear_mon();
        for (int k = 0; k < N; k++) fill[k] = 0;

        // Single requester cam2, then rr pointer check via cam3 before cam0
        do_reset();
        enable_i = 1'b1;
        c0 = cyc;
        fill[2] = 64;
        push_burst(2);
        wait_done(1, 300);
        chk("t1_sel", g_sel[0], 2);
        chk("t1_len", g_len[0], B);
        chk("t1_latency", g_rise[0] - c0, 1);
        chk("t1_de_lag_first", de_first - g_rise[0], 1);
        chk("t1_de_lag_last", de_last - g_last[0], 1);
        chk("t1_de_cycles", de_cycles, B);
        chk("t1_done_lag", d_cyc[0] - g_last[0], 3);
        fill[0] = rdptr[0] + 64;
        fill[3] = rdptr[3] + 64;
        push_burst(3);
        push_burst(0);
        wait_done(3, 400);
        chk("t1_rr_next", g_sel[1], 3);
        chk("t1_rr_wrap", g_sel[2], 0);
        chk("t1_sel_held", sel_id_o, 0);
        enable_i = 1'b0;

        // All cams full: rotation 0,1,2,3,0 with 4-cycle gaps
        do_reset();
        enable_i = 1'b1;
        set_all(200);
        push_burst(0); push_burst(1); push_burst(2);
        push_burst(3); push_burst(0);
        wait_grants(5, 2000);
        enable_i = 1'b0;
        wait_done(5, 300);
        repeat (100) @(posedge pclk);
        #1;
        chk("t2_grants", g_rise.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_sel", g_sel[i], i % N);
            chk("t2_len", g_len[i], B);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t2_gap", g_rise[i+1] - g_last[i] - 1, 4);
        end

        // Count one short of a burst never qualifies
        do_reset();
        enable_i = 1'b1;
        fill[1] = 63;
        repeat (1000) @(posedge pclk);
        #1;
        chk("t3_no_rd", rd_cycles, 0);
        chk("t3_no_de", de_cycles, 0);
        c0 = cyc;
        fill[1] = 64;
        push_burst(1);
        wait_done(1, 300);
        chk("t3_latency", g_rise[0] - c0, 1);
        chk("t3_sel", g_sel[0], 1);
        chk("t3_len", g_len[0], B);

        // enable drop mid-burst: burst finishes, no new grant
        do_reset();
        enable_i = 1'b1;
        set_all(200);
        push_burst(0);
        wait_len(10, 200);
        enable_i = 1'b0;
        wait_done(1, 300);
        repeat (200) @(posedge pclk);
        #1;
        chk("t4_grants", g_rise.size(), 1);
        chk("t4_len", g_len[0], B);
        chk("t4_dones", d_cyc.size(), 1);
        chk("t4_idle_busy", busy_o, 0);

        // Reset mid-burst, then cam0 wins with a full burst
        do_reset();
        enable_i = 1'b1;
        set_all(200);
        push_burst(0);
        wait_len(30, 200);
        do_reset();
        c0 = cyc;
        set_all(200);
        push_burst(0);
        wait_grants(1, 100);
        enable_i = 1'b0;
        wait_done(1, 300);
        chk("t5_sel", g_sel[0], 0);
        chk("t5_len", g_len[0], B);
        chk("t5_latency", g_rise[0] - c0, 1);

        // White/black pair through cam3 into the reference converter
        do_reset();
        pat3 = 1'b1;
        enable_i = 1'b1;
        fill[3] = 64;
        push_burst(3);
        wait_done(1, 300);
        enable_i = 1'b0;
        chk("t6_pix_seen", pix_seen, 1);
        chk("t6_white", pix0, 16'hFFFF);
        chk("t6_black", pix1, 16'h0000);
        chk("t6_tag", pix_sel, 3);
        chk("t6_before_done", (pix_cyc < d_cyc[0]), 1);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_conv_arbiter.md
Name: cam_conv_arbiter

Overview:
- Shares one yuv422_to_rgb565 converter between N_CAM camera input FIFOs in the 360-camera capture path.
- Grants one camera at a time, round-robin, for a fixed burst of BURST 16-bit YUV words.
- Streams the granted camera's words into the converter with pair-aligned de.
- Holds a camera tag stable until the converter has emitted the burst's last pixel, so downstream frame writers can route RGB565 pixels per camera.

Parameters:
- N_CAM, 4, number of camera FIFOs (2..8).
- BURST, 64, words per grant; must be even and >= 2, so UYVY/YUYV pairs are never split.
- CNT_W, 11, width of each FIFO fill-count input.
- ID_W, 2, width of the camera tag; must satisfy 2^ID_W >= N_CAM.

Ports:
- pclk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable_i  in  1  permits new grants.
- fifo_cnt_i  in  N_CAM*CNT_W  fill counts; camera k uses bits [k*CNT_W +: CNT_W].
- fifo_data_i  in  N_CAM*16  FIFO read data; read latency is 1 cycle.
- fifo_rd_o  out  N_CAM  one-hot read strobes.
- conv_de_o  out  1  word valid to the converter de_i.
- conv_data_o  out  16  word to the converter uyvy_i.
- sel_id_o  out  ID_W  index of the granted camera.
- busy_o  out  1  high in READ and DRAIN.
- burst_done_o  out  1  single-cycle pulse at burst completion.

Behaviour:
- Reset (synchronous, any state): next edge forces state=IDLE, fifo_rd_o=0, conv_de_o=0, conv_data_o=0, sel_id_o=0, busy_o=0, burst_done_o=0, rr_ptr=0, word counter=0. A burst in flight is abandoned; the partial converter pair is discarded.
- States: IDLE, READ, DRAIN.
- IDLE:
  - If enable_i is high, scan cameras starting at rr_ptr, wrapping modulo N_CAM.
  - The first camera with fifo_cnt >= BURST is latched into sel_id_o; go to READ on the next edge.
  - Otherwise stay in IDLE with all strobes 0.
  - Decision takes one cycle: fifo_rd_o first rises on the cycle after IDLE sees a qualifying count.
- READ:
  - fifo_rd_o[sel] is high for exactly BURST consecutive cycles; all other bits stay 0.
  - A word counter runs 0..BURST-1; on the last read, go to DRAIN.
- Datapath:
  - conv_de_o is fifo_rd_o[sel] delayed by one register.
  - conv_data_o is fifo_data_i[sel] registered on the same edge.
  - conv_de_o is therefore high for BURST contiguous cycles, starting one cycle after the first fifo_rd_o.
  - conv_data_o holds its last value while conv_de_o is low.
- DRAIN:
  - Lasts 3 cycles: 1 for FIFO latency plus 2 for the converter's second-pixel emission.
  - burst_done_o pulses on the 3rd DRAIN cycle.
  - On that cycle rr_ptr <= (sel+1) mod N_CAM; next state is IDLE.
- sel_id_o changes only on the IDLE->READ transition; it is held through READ and DRAIN and after returning to IDLE.
- enable_i deasserted in READ or DRAIN: the current burst completes normally; no new grant until enable_i is high again.
- Simultaneous qualifying requests: only rr_ptr order decides the winner.
- A camera granted last is lowest priority next round, so no camera starves while its count stays >= BURST.
- Fill counts below BURST never receive a grant, so a partial burst is never read.
- The block does not underflow-check FIFOs: fill counts must not drop except by this block's reads.

Test Plan:
- Only cam2 has fifo_cnt=64, enable=1 -> one cycle later fifo_rd_o=4'b0100 for 64 cycles; conv_de_o high for 64 cycles lagging by 1; sel_id_o=2; burst_done_o pulses 3 cycles after the last read; rr_ptr=3.
- All cams at fifo_cnt=200, BURST=64 -> grant order 0,1,2,3,0; each grant exactly 64 reads; 4 idle cycles (3 DRAIN + 1 IDLE decision) between bursts.
- cam1 fifo_cnt=63, others 0 -> no fifo_rd_o and no conv_de_o for 1000 cycles; raising it to 64 -> grant within 1 cycle.
- enable_i drops at read 10 of a burst on cam0 -> all 64 reads complete, burst_done_o pulses, then no further grants while cams stay full.
- rst asserted at read 30 -> next edge all outputs 0 and state IDLE; after release, cam0 is granted first and its burst is full length.
- Known UYVY words 0x80EB,0x8010 routed through cam3 into a real converter -> RGB pixels white then black appear tagged sel_id_o=3, both before burst_done_o.
